// File: rtl/mil_transmitter_if.sv
// Bus bundles for mil_transmitter: word push port, 1553 line legs, arbiter control.
`timescale 1ns/1ps

interface mil_push_if;
  typedef struct packed {
    logic [1:0]  dataType;
    logic [15:0] content;
  } push_data_t;

  logic       request;
  push_data_t data;
  logic       done;

  modport master (output request, output data, input done);
  modport slave  (input request, input data, output done);
endinterface

interface mil_line_if;
  logic TXout;
  logic nTXout;
  logic RXin;
  logic nRXin;

  modport master (output TXout, output nTXout, input RXin, input nRXin);
  modport slave  (input TXout, input nTXout, output RXin, output nRXin);
endinterface

interface mil_control_if;
  logic grant;
  logic busy;

  modport master (output grant, input busy);
  modport slave  (input grant, output busy);
endinterface

// File: rtl/mil_transmitter.sv
// MIL-STD-1553 word transmitter: one-entry holding buffer feeding a Manchester-II
// serialiser (sync, 16 data bits MSB first, odd parity). Half-bit slots are paced by
// edges of the synchronised ioClk strobe.
// Optional feature: define MIL_TX_GAP_EN to insert 4 idle half-bit slots after each frame.
`timescale 1ns/1ps

module mil_transmitter (
  input  logic          clk,
  input  logic          rst,
  input  logic          ioClk,
  mil_push_if.slave     push,
  mil_line_if.master    mil,
  mil_control_if.slave  control
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSync   = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
`ifdef MIL_TX_GAP_EN
  localparam logic [2:0] StGap    = 3'd4;
`endif

  logic [2:0]  io_sync_q, io_sync_d;
  logic        tick;

  logic        hold_valid_q, hold_valid_d;
  logic [1:0]  hold_type_q, hold_type_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        done_q, done_d;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        ntx_q, ntx_d;

  logic        slot_free;
  logic        start;
  logic        accept;
  logic        level;
  logic        active;
  logic        unused_rx;

  // Receive legs belong to the receiver; tie them off here.
  assign unused_rx = mil.RXin ^ mil.nRXin;

  // Any edge of the synchronised strobe opens a new half-bit slot.
  assign tick = io_sync_q[1] ^ io_sync_q[2];

  // A new frame may start from idle or right after the last slot of the previous one.
`ifdef MIL_TX_GAP_EN
  assign slot_free = (state_q == StIdle) || ((state_q == StGap) && (cnt_q == 5'd3));
`else
  assign slot_free = (state_q == StIdle) || ((state_q == StParity) && (cnt_q == 5'd1));
`endif
  assign start  = tick && hold_valid_q && control.grant && slot_free;
  // start needs a full slot and accept an empty one, so the frame start always wins.
  assign accept = push.request && !hold_valid_q && !done_q;

  // Two-stage synchroniser plus previous-value stage for edge detection.
  always_comb begin
    io_sync_d = {io_sync_q[1:0], ioClk};
  end

  // Holding register: freed by a frame start, filled by an accepted push.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_type_d  = hold_type_q;
    hold_data_d  = hold_data_q;
    done_d       = 1'b0;
    if (start) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_type_d  = push.data.dataType;
      hold_data_d  = push.data.content;
      done_d       = 1'b1;
    end
  end

  // Frame sequencer: advances one half-bit slot per tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    word_d  = word_q;
    if (start) begin
      state_d = StSync;
      cnt_d   = 5'd0;
      type_d  = hold_type_q;
      word_d  = hold_data_q;
    end else if (tick) begin
      unique case (state_q)
        StIdle: ;
        StSync: begin
          if (cnt_q == 5'd5) begin
            state_d = StData;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StData: begin
          if (cnt_q == 5'd31) begin
            state_d = StParity;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StParity: begin
          if (cnt_q == 5'd1) begin
`ifdef MIL_TX_GAP_EN
            state_d = StGap;
`else
            state_d = StIdle;
`endif
            cnt_d = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`ifdef MIL_TX_GAP_EN
        StGap: begin
          if (cnt_q == 5'd3) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // Line level for the slot being entered; data and parity bits are high-then-low for a 1.
  always_comb begin
    level  = 1'b0;
    active = 1'b0;
    unique case (state_d)
      StSync: begin
        active = 1'b1;
        if ((type_d == 2'd1) || (type_d == 2'd2)) level = (cnt_d < 5'd3);
        else                                      level = (cnt_d >= 5'd3);
      end
      StData: begin
        active = 1'b1;
        level  = word_d[4'd15 - cnt_d[4:1]] ^ cnt_d[0];
      end
      StParity: begin
        active = 1'b1;
        level  = (~^word_d) ^ cnt_d[0];
      end
      default: ;
    endcase
    tx_d  = active & level;
    ntx_d = active & ~level;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_sync_q    <= 3'b000;
      hold_valid_q <= 1'b0;
      hold_type_q  <= 2'd0;
      hold_data_q  <= 16'h0000;
      done_q       <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= 5'd0;
      type_q       <= 2'd0;
      word_q       <= 16'h0000;
      tx_q         <= 1'b0;
      ntx_q        <= 1'b0;
    end else begin
      io_sync_q    <= io_sync_d;
      hold_valid_q <= hold_valid_d;
      hold_type_q  <= hold_type_d;
      hold_data_q  <= hold_data_d;
      done_q       <= done_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      word_q       <= word_d;
      tx_q         <= tx_d;
      ntx_q        <= ntx_d;
    end
  end

  assign push.done    = done_q;
  assign mil.TXout    = tx_q;
  assign mil.nTXout   = ntx_q;
  assign control.busy = hold_valid_q | (state_q != StIdle);

endmodule

// File: tb/tb_mil_transmitter.sv
// Self-checking bench for mil_transmitter: expected frames are queued as words are
// pushed, and compared against half-bit slots sampled from the line.
`timescale 1ns/1ps

module tb_mil_transmitter;

`ifdef MIL_TX_GAP_EN
  localparam int GapSlots = 4;
`else
  localparam int GapSlots = 0;
`endif

  localparam logic [1:0] LvH = 2'b10;
  localparam logic [1:0] LvL = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ioClk = 1'b0;

  mil_push_if    push_if ();
  mil_line_if    mil_if ();
  mil_control_if ctl_if ();

  mil_transmitter dut (
    .clk     (clk),
    .rst     (rst),
    .ioClk   (ioClk),
    .push    (push_if),
    .mil     (mil_if),
    .control (ctl_if)
  );

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int idle_run = 0;

  logic [79:0] exp_q[$];
  logic [1:0]  obs_q[$];
  int          obs_idle_q[$];

  always #5 clk = ~clk;

  // Half-bit slot = 8 clk cycles.
  initial forever begin
    repeat (8) @(negedge clk);
    ioClk = ~ioClk;
  end

  // Sample each slot well after its level has settled; record active half-bits.
  initial forever begin
    logic [1:0] line;
    @(ioClk);
    repeat (5) @(posedge clk);
    #1;
    line = {mil_if.TXout, mil_if.nTXout};
    if (line == 2'b00) begin
      idle_run++;
    end else begin
      obs_q.push_back(line);
      obs_idle_q.push_back(idle_run);
      idle_run = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (push_if.done === 1'b1) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [79:0] frame_vec(input logic [1:0] t, input logic [15:0] c);
    logic [79:0] v;
    logic        p;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      if (t == 2'd1 || t == 2'd2) v = {v[77:0], (i < 3) ? LvH : LvL};
      else                        v = {v[77:0], (i < 3) ? LvL : LvH};
    end
    for (int b = 15; b >= 0; b--) begin
      v = c[b] ? {v[75:0], LvH, LvL} : {v[75:0], LvL, LvH};
    end
    p = 1'b1;
    for (int b = 0; b < 16; b++) p = p ^ c[b];
    v = p ? {v[75:0], LvH, LvL} : {v[75:0], LvL, LvH};
    return v;
  endfunction

  task automatic push_word(input logic [1:0] t, input logic [15:0] c, output bit ok);
    exp_q.push_back(frame_vec(t, c));
    @(negedge clk);
    push_if.request = 1'b1;
    push_if.data.dataType = t;
    push_if.data.content  = c;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (push_if.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    push_if.request = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic pop_frame(output logic [79:0] v, output int idle_first);
    v = '0;
    idle_first = obs_idle_q[0];
    for (int i = 0; i < 40; i++) begin
      v = {v[77:0], obs_q.pop_front()};
      void'(obs_idle_q.pop_front());
    end
  endtask

  task automatic test_reset();
    push_if.request = 1'b0;
    push_if.data = '0;
    ctl_if.grant = 1'b0;
    mil_if.RXin = 1'b0;
    mil_if.nRXin = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({mil_if.TXout, mil_if.nTXout} !== 2'b00)
      $display("FAIL reset_line: got %b required 00", {mil_if.TXout, mil_if.nTXout});
    else passed++;
    total++; if (push_if.done !== 1'b0)
      $display("FAIL reset_done: got %b required 0", push_if.done); else passed++;
    total++; if (ctl_if.busy !== 1'b0)
      $display("FAIL reset_busy: got %b required 0", ctl_if.busy); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({mil_if.TXout, mil_if.nTXout} !== 2'b00)
      $display("FAIL post_reset_line: got %b required 00", {mil_if.TXout, mil_if.nTXout});
    else passed++;
  endtask

  task automatic test_hold_no_grant();
    bit ok;
    int d0;
    d0 = done_cnt;
    push_word(2'd1, 16'h02A1, ok);
    total++; if (!ok) $display("FAIL hold_push_done: got timeout required done"); else passed++;
    repeat (200) @(posedge clk);
    #1;
    total++; if (done_cnt - d0 != 1)
      $display("FAIL hold_done_pulses: got %0d required 1", done_cnt - d0); else passed++;
    total++; if (ctl_if.busy !== 1'b1)
      $display("FAIL hold_busy: got %b required 1", ctl_if.busy); else passed++;
    total++; if (obs_q.size() != 0)
      $display("FAIL hold_line_idle: got %0d active slots required 0", obs_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [79:0] got, expv;
    int idle;
    @(negedge clk);
    ctl_if.grant = 1'b1;
    push_word(2'd3, 16'h02A1, ok);
    total++; if (!ok || {mil_if.TXout, mil_if.nTXout} !== LvH)
      $display("FAIL b2b_done_after_start: got ok=%0d line=%b required ok=1 line=10",
               ok, {mil_if.TXout, mil_if.nTXout});
    else passed++;
    wait_obs(80, ok);
    total++;
    if (!ok) begin
      $display("FAIL b2b_frames: got %0d slots required 80", obs_q.size());
      obs_q.delete(); obs_idle_q.delete(); exp_q.delete();
      return;
    end
    passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL b2b_frame1: got %h required %h", got, expv); else passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL b2b_frame2: got %h required %h", got, expv); else passed++;
    total++; if (idle != GapSlots)
      $display("FAIL b2b_gap: got %0d idle slots required %0d", idle, GapSlots); else passed++;
    repeat (80) @(posedge clk);
    #1;
    total++; if (ctl_if.busy !== 1'b0 || {mil_if.TXout, mil_if.nTXout} !== 2'b00)
      $display("FAIL b2b_after_idle: got busy=%b line=%b required busy=0 line=00",
               ctl_if.busy, {mil_if.TXout, mil_if.nTXout});
    else passed++;
  endtask

  task automatic test_parity();
    bit ok1, ok2;
    logic [79:0] got, expv;
    int idle;
    push_word(2'd3, 16'h0001, ok1);
    push_word(2'd3, 16'hFFFF, ok2);
    wait_obs(80, ok1);
    total++;
    if (!ok1 || !ok2) begin
      $display("FAIL parity_frames: got %0d slots required 80", obs_q.size());
      obs_q.delete(); obs_idle_q.delete(); exp_q.delete();
      return;
    end
    passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL parity0_frame: got %h required %h", got, expv); else passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL parity1_frame: got %h required %h", got, expv); else passed++;
    total++; if (idle != GapSlots)
      $display("FAIL parity_gap: got %0d idle slots required %0d", idle, GapSlots); else passed++;
    repeat (80) @(posedge clk);
  endtask

  task automatic test_grant_drop();
    bit ok1, ok2;
    logic [79:0] got, expv;
    int idle;
    push_word(2'd1, 16'h1234, ok1);
    push_word(2'd2, 16'hBEEF, ok2);
    @(negedge clk);
    ctl_if.grant = 1'b0;
    wait_obs(40, ok1);
    total++;
    if (!ok1 || !ok2) begin
      $display("FAIL grant_first_frame: got %0d slots required 40", obs_q.size());
      obs_q.delete(); obs_idle_q.delete(); exp_q.delete();
      ctl_if.grant = 1'b1;
      return;
    end
    passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL grant_frameA: got %h required %h", got, expv); else passed++;
    repeat (300) @(posedge clk);
    #1;
    total++; if (obs_q.size() != 0 || ctl_if.busy !== 1'b1)
      $display("FAIL grant_held: got slots=%0d busy=%b required slots=0 busy=1",
               obs_q.size(), ctl_if.busy);
    else passed++;
    @(negedge clk);
    ctl_if.grant = 1'b1;
    wait_obs(40, ok1);
    total++;
    if (!ok1) begin
      $display("FAIL grant_second_frame: got %0d slots required 40", obs_q.size());
      obs_q.delete(); obs_idle_q.delete(); exp_q.delete();
      return;
    end
    passed++;
    pop_frame(got, idle);
    expv = exp_q.pop_front();
    total++; if (got !== expv)
      $display("FAIL grant_frameB: got %h required %h", got, expv); else passed++;
    repeat (80) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    push_word(2'd3, 16'h5A5A, ok1);
    push_word(2'd2, 16'h00FF, ok2);
    wait_obs(10, ok1);
    total++; if (!ok1 || !ok2)
      $display("FAIL rstmid_started: got %0d slots required 10", obs_q.size()); else passed++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({mil_if.TXout, mil_if.nTXout} !== 2'b00 || ctl_if.busy !== 1'b0)
      $display("FAIL rstmid_immediate: got line=%b busy=%b required line=00 busy=0",
               {mil_if.TXout, mil_if.nTXout}, ctl_if.busy);
    else passed++;
    repeat (3) @(posedge clk);
    exp_q.delete();
    obs_q.delete();
    obs_idle_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    total++; if (obs_q.size() != 0 || ctl_if.busy !== 1'b0)
      $display("FAIL rstmid_no_residual: got slots=%0d busy=%b required slots=0 busy=0",
               obs_q.size(), ctl_if.busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_hold_no_grant();
    test_back_to_back();
    test_parity();
    test_grant_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
